// File: rtl/bus_arbiter_mc.sv
// bus_arbiter_mc: per-bus packet arbiter moving FIFO heads to destination devices.
// Rev 1.0
`default_nettype none

module bus_arbiter_mc #(
  parameter int         BITS      = 1,
  parameter int         DRVRS     = 4,
  parameter int         PCKG_SZ   = 16,
  parameter logic [7:0] BROADCAST = 8'hFF,
  parameter int         MODE      = 1,
  parameter int         CNT_W     = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [BITS-1:0][DRVRS-1:0]              pndng,
  input  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop,
  input  logic [BITS-1:0][DRVRS-1:0]              full,
  output logic [BITS-1:0][DRVRS-1:0]              pop,
  output logic [BITS-1:0][DRVRS-1:0]              push,
  output logic [BITS-1:0][PCKG_SZ-1:0]            D_push,
  output logic [BITS-1:0][CNT_W-1:0]              pkt_cnt,
  output logic [BITS-1:0][CNT_W-1:0]              drop_cnt
);

  localparam int IW = $clog2(DRVRS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_ROUTE = 2'd2,
    S_PUSH  = 2'd3
  } state_t;

  generate
    for (genvar b = 0; b < BITS; b++) begin : g_bus
      state_t             r_state, w_state_nxt;
      logic [PCKG_SZ-1:0] r_pkt, w_pkt_nxt, r_dpush, w_dpush_nxt;
      logic [IW-1:0]      r_gnt, w_gnt_nxt, r_ptr, w_ptr_nxt, w_sel;
      logic [DRVRS-1:0]   r_pop, w_pop_nxt, r_push, w_push_nxt, w_mask;
      logic [CNT_W-1:0]   r_pcnt, w_pcnt_nxt, r_dcnt, w_dcnt_nxt;
      logic [7:0]         w_dest;
      logic               w_valid;

      // Scan downward so the lowest offset from the search start wins.
      always_comb begin
        w_sel = '0;
        for (int i = DRVRS - 1; i >= 0; i--) begin
          if (pndng[b][(MODE == 1) ? (int'(r_ptr) + i) % DRVRS : i])
            w_sel = IW'((MODE == 1) ? (int'(r_ptr) + i) % DRVRS : i);
        end
      end

      assign w_dest = r_pkt[PCKG_SZ-1 -: 8];

      always_comb begin
        w_mask  = '0;
        w_valid = 1'b0;
        if (int'(w_dest) < DRVRS) begin
          w_valid = 1'b1;
          for (int j = 0; j < DRVRS; j++) w_mask[j] = (int'(w_dest) == j);
        end else if (w_dest == BROADCAST) begin
          w_valid = 1'b1;
          for (int j = 0; j < DRVRS; j++) w_mask[j] = (int'(r_gnt) != j);
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_pkt_nxt   = r_pkt;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_pop_nxt   = '0;
        w_push_nxt  = '0;
        w_dpush_nxt = r_dpush;
        w_pcnt_nxt  = r_pcnt;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
          // PUSH doubles as a grant slot so back-to-back packets are 3 cycles apart.
          S_IDLE, S_PUSH: begin
            if (r_state == S_PUSH && r_pcnt != '1) w_pcnt_nxt = r_pcnt + CNT_W'(1);
            if (|pndng[b]) begin
              w_gnt_nxt   = w_sel;
              w_pkt_nxt   = D_pop[b][w_sel];
              w_pop_nxt   = DRVRS'(1) << w_sel;
              w_ptr_nxt   = (w_sel == IW'(DRVRS - 1)) ? '0 : w_sel + IW'(1);
              w_state_nxt = S_POP;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
          S_POP: w_state_nxt = S_ROUTE;
          S_ROUTE: begin
            if (!w_valid) begin
              if (r_dcnt != '1) w_dcnt_nxt = r_dcnt + CNT_W'(1);
              w_state_nxt = S_IDLE;
            end else if ((w_mask & full[b]) == '0) begin
              w_push_nxt  = w_mask;
              w_dpush_nxt = r_pkt;
              w_state_nxt = S_PUSH;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_state <= S_IDLE;
          r_pkt   <= '0;
          r_gnt   <= '0;
          r_ptr   <= '0;
          r_pop   <= '0;
          r_push  <= '0;
          r_dpush <= '0;
          r_pcnt  <= '0;
          r_dcnt  <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_pkt   <= w_pkt_nxt;
          r_gnt   <= w_gnt_nxt;
          r_ptr   <= w_ptr_nxt;
          r_pop   <= w_pop_nxt;
          r_push  <= w_push_nxt;
          r_dpush <= w_dpush_nxt;
          r_pcnt  <= w_pcnt_nxt;
          r_dcnt  <= w_dcnt_nxt;
        end
      end

      assign pop[b]      = r_pop;
      assign push[b]     = r_push;
      assign D_push[b]   = r_dpush;
      assign pkt_cnt[b]  = r_pcnt;
      assign drop_cnt[b] = r_dcnt;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_mc.sv
// tb_bus_arbiter_mc: fixed-priority and round-robin arbiters against a transaction-timing model.
`default_nettype none

module tb_bus_arbiter_mc;

  logic                   clk;
  logic                   reset;
  logic [0:0][3:0]        pndng;
  logic [0:0][3:0][15:0]  D_pop;
  logic [0:0][3:0]        full;
  logic [0:0][3:0]        pop_fp, push_fp, pop_rr, push_rr;
  logic [0:0][15:0]       dp_fp, dp_rr;
  logic [0:0][7:0]        pc_fp, dc_fp, pc_rr, dc_rr;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter_mc #(.BITS(1), .DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF), .MODE(0), .CNT_W(8)) u_fp (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
    .pop(pop_fp), .push(push_fp), .D_push(dp_fp), .pkt_cnt(pc_fp), .drop_cnt(dc_fp));

  bus_arbiter_mc #(.BITS(1), .DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF), .MODE(1), .CNT_W(8)) u_rr (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
    .pop(pop_rr), .push(push_rr), .D_push(dp_rr), .pkt_cnt(pc_rr), .drop_cnt(dc_rr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model index 0 = fixed priority, 1 = round robin; times are edge numbers.
  int          edge_n;
  int          m_busy[2], m_gnt[2], m_route_from[2], m_free_at[2];
  int          m_ptr[2], m_pc[2], m_dc[2], m_pc_pend[2];
  logic [15:0] m_lat[2], m_dp[2];
  logic [3:0]  e_pop[2], e_push[2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_gnt[m] = 0; m_route_from[m] = 0; m_free_at[m] = 0;
      m_ptr[m] = 0; m_pc[m] = 0; m_dc[m] = 0; m_pc_pend[m] = 0;
      m_lat[m] = '0; m_dp[m] = '0; e_pop[m] = '0; e_push[m] = '0;
    end
  endtask

  // Predicts outputs after the coming rising edge from the inputs presented now.
  task automatic model_step();
    int d, msk, g, c;
    bit ok;
    edge_n++;
    for (int m = 0; m < 2; m++) begin
      e_pop[m]  = '0;
      e_push[m] = '0;
      if (m_pc_pend[m] != 0) begin
        if (m_pc[m] < 255) m_pc[m]++;
        m_pc_pend[m] = 0;
      end
      if (m_busy[m] != 0 && edge_n >= m_route_from[m]) begin
        d  = int'(m_lat[m][15:8]);
        ok = 1'b1;
        msk = 0;
        if (d < 4)         msk = 1 << d;
        else if (d == 255) msk = 15 & ~(1 << m_gnt[m]);
        else               ok = 1'b0;
        if (!ok) begin
          if (m_dc[m] < 255) m_dc[m]++;
          m_busy[m]    = 0;
          m_free_at[m] = edge_n + 1;
        end else if ((msk & int'(full[0])) == 0) begin
          e_push[m]    = 4'(msk);
          m_dp[m]      = m_lat[m];
          m_busy[m]    = 0;
          m_free_at[m] = edge_n + 1;
          m_pc_pend[m] = 1;
        end
      end else if (m_busy[m] == 0 && edge_n >= m_free_at[m] && pndng[0] != 4'd0) begin
        g = -1;
        for (int i = 0; i < 4; i++) begin
          c = (m == 1) ? (m_ptr[m] + i) % 4 : i;
          if (g < 0 && pndng[0][c]) g = c;
        end
        e_pop[m]        = 4'(1 << g);
        m_gnt[m]        = g;
        m_lat[m]        = D_pop[0][g];
        m_busy[m]       = 1;
        m_route_from[m] = edge_n + 2;
        m_ptr[m]        = (g + 1) % 4;
      end
    end
  endtask

  task automatic check_all();
    check("fp.pop",  32'(pop_fp[0]),  32'(e_pop[0]));
    check("fp.push", 32'(push_fp[0]), 32'(e_push[0]));
    check("fp.dpsh", 32'(dp_fp[0]),   32'(m_dp[0]));
    check("fp.pcnt", 32'(pc_fp[0]),   32'(m_pc[0]));
    check("fp.dcnt", 32'(dc_fp[0]),   32'(m_dc[0]));
    check("rr.pop",  32'(pop_rr[0]),  32'(e_pop[1]));
    check("rr.push", 32'(push_rr[0]), 32'(e_push[1]));
    check("rr.dpsh", 32'(dp_rr[0]),   32'(m_dp[1]));
    check("rr.pcnt", 32'(pc_rr[0]),   32'(m_pc[1]));
    check("rr.dcnt", 32'(dc_rr[0]),   32'(m_dc[1]));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    pndng = '0;
    full  = '0;
    for (int i = 0; i < 4; i++) D_pop[0][i] = '0;
  endtask

  // Entered at a falling edge; reset drops mid-cycle and outputs must clear before any edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    model_reset();
    check("rst.pop",  32'({pop_fp[0], pop_rr[0]}), 32'd0);
    check("rst.push", 32'({push_fp[0], push_rr[0]}), 32'd0);
    check("rst.dpsh", 32'({dp_fp[0], dp_rr[0]}), 32'd0);
    check("rst.cnt",  32'({pc_fp[0], dc_fp[0], pc_rr[0], dc_rr[0]}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  int gq_fp[$];
  int gq_rr[$];
  int exp_fp[5] = '{0, 0, 0, 0, 0};
  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int r;
  logic [7:0] dst;

  initial begin
    reset  = 1'b0;
    edge_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b1;

    // Unicast to device 2.
    pndng[0] = 4'b0001; D_pop[0][0] = 16'h02AB;
    step();
    idle_inputs();
    repeat (4) step();
    check("uni.pcnt", 32'(pc_rr[0]), 32'd1);

    // Broadcast from device 1 reaches everyone else.
    do_reset();
    pndng[0] = 4'b0010; D_pop[0][1] = 16'hFF55;
    step();
    idle_inputs();
    repeat (4) step();

    // Arbitration with all devices pending.
    do_reset();
    pndng[0] = 4'b1111;
    repeat (15) begin
      step();
      if (pop_fp[0] != '0) gq_fp.push_back(onehot_idx(pop_fp[0]));
      if (pop_rr[0] != '0) gq_rr.push_back(onehot_idx(pop_rr[0]));
    end
    check("arb.nfp", 32'(gq_fp.size()), 32'd5);
    check("arb.nrr", 32'(gq_rr.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("arb.fp", 32'((i < gq_fp.size()) ? gq_fp[i] : -1), 32'(exp_fp[i]));
      check("arb.rr", 32'((i < gq_rr.size()) ? gq_rr[i] : -1), 32'(exp_rr[i]));
    end

    // Backpressure on device 2 while device 3 keeps requesting.
    do_reset();
    pndng[0] = 4'b0001; D_pop[0][0] = 16'h0211; full[0] = 4'b0100;
    step();
    pndng[0] = 4'b1000; D_pop[0][0] = '0; D_pop[0][3] = 16'h0322;
    repeat (4) step();
    full[0] = 4'b0000;
    repeat (6) step();

    // Invalid destination is dropped.
    do_reset();
    pndng[0] = 4'b1000; D_pop[0][3] = 16'h07C3;
    step();
    idle_inputs();
    repeat (4) step();
    check("inv.dcnt", 32'(dc_rr[0]), 32'd1);
    check("inv.pcnt", 32'(pc_rr[0]), 32'd0);

    // Reset in the third cycle of a transfer discards the packet.
    do_reset();
    pndng[0] = 4'b0001; D_pop[0][0] = 16'h0299;
    step();
    idle_inputs();
    step();
    do_reset();
    repeat (5) step();

    // Random traffic with mixed destinations and backpressure.
    do_reset();
    repeat (400) begin
      pndng[0] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      full[0]  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      dst = 8'(r % 4);
        else if (r < 8) dst = 8'hFF;
        else            dst = 8'($urandom_range(4, 254));
        D_pop[0][i] = {dst, 8'($urandom)};
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter_mc.md
BUS_ARBITER_MC -- requirements
Module: bus_arbiter_mc

Interface
REQ-001 SHALL have parameter BITS, default 1: number of independent buses.
REQ-002 SHALL have parameter DRVRS, default 4: devices per bus, 2..16.
REQ-003 SHALL have parameter PCKG_SZ, default 16: packet width, >8; bits [PCKG_SZ-1:PCKG_SZ-8] are the destination ID.
REQ-004 SHALL have parameter BROADCAST, default 8'hFF: destination ID meaning all devices except the source.
REQ-005 SHALL have parameter MODE, default 1: 0 = fixed priority, 1 = round-robin.
REQ-006 SHALL have parameter CNT_W, default 8: width of the statistics counters.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 reset  input  1  reset is asynchronous and active-low.
REQ-009 pndng  input  [BITS][DRVRS]  device FIFO non-empty; head data valid on D_pop.
REQ-010 D_pop  input  [BITS][DRVRS][PCKG_SZ]  head-of-FIFO packet per device.
REQ-011 full  input  [BITS][DRVRS]  destination device cannot accept a push.
REQ-012 pop  output  [BITS][DRVRS]  one-cycle dequeue strobe to the source device.
REQ-013 push  output  [BITS][DRVRS]  one-cycle enqueue strobe to the destination device(s).
REQ-014 D_push  output  [BITS][PCKG_SZ]  packet driven to the destinations of each bus.
REQ-015 pkt_cnt  output  [BITS][CNT_W]  delivered packets per bus, saturating.
REQ-016 drop_cnt  output  [BITS][CNT_W]  dropped packets per bus, saturating.

Function
REQ-017 Each bus SHALL run an independent FSM (IDLE, POP, ROUTE, PUSH); buses SHALL NOT interact.
REQ-018 IDLE: at a rising edge with any pndng set, SHALL select grant g, latch D_pop[g], set pop[g]=1 and enter POP; with no pndng set it SHALL stay in IDLE.
REQ-019 POP: pop[g] SHALL be high for exactly this one cycle; the next edge SHALL clear pop and enter ROUTE.
REQ-020 ROUTE: SHALL decode the destination ID into a target mask:
- ID < DRVRS: that single device; self-addressing is allowed.
- ID == BROADCAST: all devices except g.
- Any other ID: invalid.
REQ-021 ROUTE with an invalid ID SHALL drop the packet, increment drop_cnt and return to IDLE with no push.
REQ-022 ROUTE with a valid mask SHALL stay in ROUTE while any targeted full bit is set; no further pop on that bus while waiting.
REQ-023 When no targeted full bit is set, ROUTE SHALL set push=mask and D_push=packet at the next edge and enter PUSH.
REQ-024 PUSH: push SHALL be high for exactly one cycle; the next edge SHALL clear push, increment pkt_cnt and enter IDLE.
REQ-025 Latency without backpressure:
- pop is high in cycle T+1 after pndng is sampled at edge T.
- push is high in cycle T+3.
- The next grant decision is at edge T+3, so back-to-back packets are 3 cycles apart.
REQ-026 MODE=0: the lowest-index pending device SHALL win.
REQ-027 MODE=1: search SHALL start at pointer p (0 after reset); after grant g, p SHALL become (g+1) mod DRVRS; p is unchanged on idle cycles.
REQ-028 D_push SHALL hold its last value outside PUSH; push and pop SHALL never be high on the same bus in the same cycle.
REQ-029 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-030 pndng dropping after grant SHALL NOT abort the transfer; the latched packet completes.

Reset
REQ-031 reset low SHALL immediately force pop=0, push=0, D_push=0, pkt_cnt=0, drop_cnt=0, all FSMs to IDLE and p=0, independent of clk.
REQ-032 Reset asserted mid-transfer SHALL discard the in-flight packet with no push after release.
REQ-033 The first grant SHALL occur no earlier than the first rising edge after reset deasserts.

Verification (BITS=1, DRVRS=4, PCKG_SZ=16, BROADCAST=8'hFF)
REQ-034 Reset: assert reset=0 mid-cycle -> all outputs 0 before the next edge; pkt_cnt=0, drop_cnt=0.
REQ-035 Unicast: pndng[0]=1, D_pop[0]=16'h02AB -> pop=4'b0001 for 1 cycle; 2 cycles later push=4'b0100 and D_push=16'h02AB; pkt_cnt=1.
REQ-036 Broadcast: pndng[1]=1, D_pop[1]=16'hFF55 -> push=4'b1101 and D_push=16'hFF55.
REQ-037 Arbitration: pndng=4'b1111 held for 5 packets:
- MODE=1 -> grant order 0,1,2,3,0.
- MODE=0 -> grant order 0,0,0,0,0.
REQ-038 Backpressure: full[2]=1 for 5 cycles during a packet to device 2 -> push withheld; push asserted 1 cycle after full[2] falls; no other pop meanwhile.
REQ-039 Invalid ID / reset: D_pop[3]=16'h07C3 -> no push and drop_cnt=1; reset asserted in cycle T+2 of a transfer -> no push after release.
